// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// one outstanding transaction at a time, LSU first with an IFU starvation guard.
//
// state  | meaning
// IDLE   | no transaction; pick a winner and latch its request
// REQ    | mem_req_valid high with latched fields, waiting for mem_req_ready
// WAIT   | request accepted, waiting for mem_resp_valid
module mem_port_arbiter #(
   parameter int DATA_LEN     = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_req_valid,
   input  logic [DATA_LEN-1:0] if_req_addr,
   output logic                if_req_ready,
   output logic                if_resp_valid,
   output logic [DATA_LEN-1:0] if_resp_data,
   input  logic                ls_req_valid,
   input  logic [DATA_LEN-1:0] ls_req_addr,
   input  logic                ls_req_wen,
   input  logic [DATA_LEN-1:0] ls_req_wdata,
   input  logic [3:0]          ls_req_wmask,
   output logic                ls_req_ready,
   output logic                ls_resp_valid,
   output logic [DATA_LEN-1:0] ls_resp_data,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [DATA_LEN-1:0] mem_addr,
   output logic                mem_wen,
   output logic [DATA_LEN-1:0] mem_wdata,
   output logic [3:0]          mem_wmask,
   input  logic                mem_resp_valid,
   input  logic [DATA_LEN-1:0] mem_resp_data,
   output logic                busy
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_t     state_q, state_d;
   logic       owner_ls_q;
   logic [3:0] starve_q;
   logic       lsu_win, ifu_win, resp_hit;

   always_comb begin
      state_d       = state_q;
      lsu_win       = 1'b0;
      ifu_win       = 1'b0;
      if_req_ready  = 1'b0;
      ls_req_ready  = 1'b0;
      mem_req_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            lsu_win      = ls_req_valid && (!if_req_valid || (starve_q < STARVE_MAX));
            ifu_win      = if_req_valid && !lsu_win;
            ls_req_ready = lsu_win;
            if_req_ready = ifu_win;
            if (lsu_win || ifu_win) state_d = S_REQ;
         end
         S_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mem_resp_valid) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign resp_hit = (state_q == S_WAIT) && mem_resp_valid;
   assign busy     = (state_q != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         owner_ls_q    <= 1'b0;
         starve_q      <= 4'd0;
         mem_addr      <= '0;
         mem_wen       <= 1'b0;
         mem_wdata     <= '0;
         mem_wmask     <= 4'd0;
         if_resp_valid <= 1'b0;
         if_resp_data  <= '0;
         ls_resp_valid <= 1'b0;
         ls_resp_data  <= '0;
      end else begin
         state_q <= state_d;
         if (lsu_win) begin
            owner_ls_q <= 1'b1;
            mem_addr   <= ls_req_addr;
            mem_wen    <= ls_req_wen;
            mem_wdata  <= ls_req_wdata;
            mem_wmask  <= ls_req_wmask;
         end else if (ifu_win) begin
            owner_ls_q <= 1'b0;
            mem_addr   <= if_req_addr;
            mem_wen    <= 1'b0;
            mem_wdata  <= '0;
            mem_wmask  <= 4'd0;
         end
         // Counts only LSU wins that made a waiting IFU lose.
         if (lsu_win && if_req_valid) begin
            if (starve_q < STARVE_MAX) starve_q <= starve_q + 4'd1;
         end else if (lsu_win || ifu_win) begin
            starve_q <= 4'd0;
         end
         if_resp_valid <= resp_hit && !owner_ls_q;
         ls_resp_valid <= resp_hit && owner_ls_q;
         if (resp_hit && !owner_ls_q) if_resp_data <= mem_resp_data;
         if (resp_hit && owner_ls_q)  ls_resp_data <= mem_resp_data;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with a response scoreboard.
module tb_mem_port_arbiter;

   localparam int DL = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req_valid, if_req_ready, if_resp_valid;
   logic [DL-1:0] if_req_addr, if_resp_data;
   logic          ls_req_valid, ls_req_wen, ls_req_ready, ls_resp_valid;
   logic [DL-1:0] ls_req_addr, ls_req_wdata, ls_resp_data;
   logic [3:0]    ls_req_wmask;
   logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, busy;
   logic [DL-1:0] mem_addr, mem_wdata, mem_resp_data;
   logic [3:0]    mem_wmask;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic          is_ls;
      logic [DL-1:0] data;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   mem_port_arbiter #(.DATA_LEN(DL), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
      .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
      .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_wen(ls_req_wen),
      .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
      .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Every response pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (if_resp_valid || ls_resp_valid) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: if_resp_valid=%0b ls_resp_valid=%0b, required no response",
                     if_resp_valid, ls_resp_valid);
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.is_ls) begin
               if (!(ls_resp_valid && !if_resp_valid) || ls_resp_data !== mon_e.data) begin
                  bad++;
                  $display("FAIL sb_ls: valid if/ls=%0b/%0b data=%h, required 0/1 data=%h",
                           if_resp_valid, ls_resp_valid, ls_resp_data, mon_e.data);
               end
            end else begin
               if (!(if_resp_valid && !ls_resp_valid) || if_resp_data !== mon_e.data) begin
                  bad++;
                  $display("FAIL sb_if: valid if/ls=%0b/%0b data=%h, required 1/0 data=%h",
                           if_resp_valid, ls_resp_valid, if_resp_data, mon_e.data);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered in the REQ cycle; returns in the response-pulse cycle (IDLE).
   task automatic mem_cycle(input int stall, input logic [DL-1:0] rdata);
      mem_req_ready = 1'b0;
      repeat (stall) tick();
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = rdata;
      tick();
      mem_resp_valid = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      total++;
      if ({busy, mem_req_valid, if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid} !== 6'b0) begin
         bad++;
         $display("FAIL reset_ctrl: busy/mreq/ifrdy/lsrdy/ifrv/lsrv=%b, required 000000",
                  {busy, mem_req_valid, if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid});
      end
      total++;
      if ({mem_addr, mem_wdata, mem_wmask, mem_wen, if_resp_data, ls_resp_data} !== '0) begin
         bad++;
         $display("FAIL reset_data: addr=%h wdata=%h wmask=%b wen=%b ifd=%h lsd=%h, required all 0",
                  mem_addr, mem_wdata, mem_wmask, mem_wen, if_resp_data, ls_resp_data);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_ifu_alone();
      if_req_valid = 1'b1;
      if_req_addr  = 32'h8000_0000;
      #1;
      total++;
      if ({if_req_ready, ls_req_ready} !== 2'b10) begin
         bad++;
         $display("FAIL ifu_grant: if/ls ready=%b, required 10", {if_req_ready, ls_req_ready});
      end
      sb.push_back('{1'b0, 32'h0010_0073});
      tick();
      if_req_valid  = 1'b0;
      if_req_addr   = 32'h1234_5678;
      mem_req_ready = 1'b1;
      #1;
      total++;
      if ({mem_req_valid, mem_wen, mem_wmask} !== 6'b100000 || mem_addr !== 32'h8000_0000 || mem_wdata !== '0) begin
         bad++;
         $display("FAIL ifu_req: valid=%b wen=%b mask=%b addr=%h wdata=%h, required 1 0 0000 80000000 0",
                  mem_req_valid, mem_wen, mem_wmask, mem_addr, mem_wdata);
      end
      tick();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h0010_0073;
      #1;
      total++;
      if (mem_req_valid !== 1'b0 || if_resp_valid !== 1'b0) begin
         bad++;
         $display("FAIL ifu_wait: mem_req_valid=%b if_resp_valid=%b, required 0 0", mem_req_valid, if_resp_valid);
      end
      tick();
      mem_resp_valid = 1'b0;
      #1;
      total++;
      if (if_resp_valid !== 1'b1 || if_resp_data !== 32'h0010_0073) begin
         bad++;
         $display("FAIL ifu_resp: valid=%b data=%h, required 1 00100073", if_resp_valid, if_resp_data);
      end
      tick();
      total++;
      if (if_resp_valid !== 1'b0 || if_resp_data !== 32'h0010_0073 || busy !== 1'b0) begin
         bad++;
         $display("FAIL ifu_after: valid=%b data=%h busy=%b, required 0 00100073 0", if_resp_valid, if_resp_data, busy);
      end
   endtask

   task automatic test_lsu_store_stall();
      ls_req_valid = 1'b1;
      ls_req_addr  = 32'h8000_1004;
      ls_req_wdata = 32'hDEAD_BEEF;
      ls_req_wmask = 4'b1111;
      ls_req_wen   = 1'b1;
      #1;
      total++;
      if ({ls_req_ready, if_req_ready} !== 2'b10) begin
         bad++;
         $display("FAIL lsu_grant: ls/if ready=%b, required 10", {ls_req_ready, if_req_ready});
      end
      sb.push_back('{1'b1, 32'h0000_5A5A});
      tick();
      ls_req_valid  = 1'b0;
      ls_req_addr   = '0;
      ls_req_wdata  = '0;
      ls_req_wmask  = 4'd0;
      ls_req_wen    = 1'b0;
      mem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if ({mem_req_valid, mem_wen, mem_wmask} !== 6'b111111 || mem_addr !== 32'h8000_1004 ||
             mem_wdata !== 32'hDEAD_BEEF || ls_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL lsu_stall%0d: valid=%b wen=%b mask=%b addr=%h wdata=%h ready=%b, required 1 1 1111 80001004 deadbeef 0",
                     i, mem_req_valid, mem_wen, mem_wmask, mem_addr, mem_wdata, ls_req_ready);
         end
         tick();
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h0000_5A5A;
      tick();
      mem_resp_valid = 1'b0;
      #1;
      total++;
      if ({ls_resp_valid, if_resp_valid} !== 2'b10) begin
         bad++;
         $display("FAIL lsu_resp: ls/if resp_valid=%b, required 10", {ls_resp_valid, if_resp_valid});
      end
      tick();
      total++;
      if ({ls_resp_valid, if_resp_valid} !== 2'b00) begin
         bad++;
         $display("FAIL lsu_once: ls/if resp_valid=%b, required 00", {ls_resp_valid, if_resp_valid});
      end
   endtask

   task automatic test_simultaneous();
      if_req_valid = 1'b1;
      if_req_addr  = 32'h8000_0200;
      ls_req_valid = 1'b1;
      ls_req_addr  = 32'h8000_2000;
      ls_req_wdata = 32'h1111_2222;
      ls_req_wmask = 4'b0011;
      ls_req_wen   = 1'b1;
      #1;
      total++;
      if ({ls_req_ready, if_req_ready} !== 2'b10) begin
         bad++;
         $display("FAIL sim_first: ls/if ready=%b, required 10", {ls_req_ready, if_req_ready});
      end
      sb.push_back('{1'b1, 32'hAAAA_0001});
      tick();
      ls_req_valid = 1'b0;
      #1;
      total++;
      if (if_req_ready !== 1'b0) begin
         bad++;
         $display("FAIL sim_req_rdy: if_req_ready=%b, required 0", if_req_ready);
      end
      mem_cycle(1, 32'hAAAA_0001);
      #1;
      total++;
      if ({ls_req_ready, if_req_ready} !== 2'b01) begin
         bad++;
         $display("FAIL sim_second: ls/if ready=%b, required 01", {ls_req_ready, if_req_ready});
      end
      sb.push_back('{1'b0, 32'hAAAA_0002});
      tick();
      if_req_valid = 1'b0;
      #1;
      total++;
      if (mem_addr !== 32'h8000_0200 || {mem_wen, mem_wmask} !== 5'b0 || mem_wdata !== '0) begin
         bad++;
         $display("FAIL sim_ifu_fields: addr=%h wen=%b mask=%b wdata=%h, required 80000200 0 0000 0",
                  mem_addr, mem_wen, mem_wmask, mem_wdata);
      end
      mem_cycle(0, 32'hAAAA_0002);
      tick();
   endtask

   task automatic test_starvation();
      logic [9:0]    order;
      logic          exp_ls;
      logic [DL-1:0] exp_addr;
      order        = 10'b0111101111;
      if_req_valid = 1'b1;
      ls_req_valid = 1'b1;
      ls_req_wen   = 1'b0;
      ls_req_wmask = 4'd0;
      ls_req_wdata = '0;
      for (int k = 0; k < 10; k++) begin
         if_req_addr = 32'h8000_3000 + 32'(k * 4);
         ls_req_addr = 32'h9000_3000 + 32'(k * 4);
         exp_ls      = order[k];
         exp_addr    = exp_ls ? ls_req_addr : if_req_addr;
         #1;
         total++;
         if ({ls_req_ready, if_req_ready} !== {exp_ls, !exp_ls}) begin
            bad++;
            $display("FAIL starve_grant%0d: ls/if ready=%b, required %b", k,
                     {ls_req_ready, if_req_ready}, {exp_ls, !exp_ls});
         end
         sb.push_back('{exp_ls, 32'hC0DE_0000 + 32'(k)});
         tick();
         total++;
         if (mem_addr !== exp_addr) begin
            bad++;
            $display("FAIL starve_addr%0d: mem_addr=%h, required %h", k, mem_addr, exp_addr);
         end
         mem_cycle(0, 32'hC0DE_0000 + 32'(k));
      end
      if_req_valid = 1'b0;
      ls_req_valid = 1'b0;
      tick();
   endtask

   task automatic test_spurious_and_reset();
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hBAD0_BAD0;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if ({if_resp_valid, ls_resp_valid, busy} !== 3'b000) begin
            bad++;
            $display("FAIL spurious%0d: ifrv/lsrv/busy=%b, required 000", i, {if_resp_valid, ls_resp_valid, busy});
         end
      end
      mem_resp_valid = 1'b0;
      if_req_valid   = 1'b1;
      if_req_addr    = 32'h8000_0040;
      tick();
      if_req_valid  = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      #1;
      total++;
      if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin
         bad++;
         $display("FAIL rst_pre_wait: busy=%b mem_req_valid=%b, required 1 0", busy, mem_req_valid);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({busy, mem_req_valid, if_resp_valid, ls_resp_valid} !== 4'b0 || mem_addr !== '0) begin
         bad++;
         $display("FAIL rst_mid: busy/mreq/ifrv/lsrv=%b addr=%h, required 0000 0",
                  {busy, mem_req_valid, if_resp_valid, ls_resp_valid}, mem_addr);
      end
      tick();
      rst_n = 1'b1;
      tick();
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hFEED_F00D;
      tick();
      mem_resp_valid = 1'b0;
      #1;
      total++;
      if ({if_resp_valid, ls_resp_valid, busy} !== 3'b000) begin
         bad++;
         $display("FAIL rst_late_resp: ifrv/lsrv/busy=%b, required 000", {if_resp_valid, ls_resp_valid, busy});
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int last_grant;
      last_grant   = 0;
      if_req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if_req_addr = 32'h8000_0100 + 32'(i * 4);
         #1;
         total++;
         if (if_req_ready !== 1'b1 || (i > 0 && if_resp_valid !== 1'b1)) begin
            bad++;
            $display("FAIL b2b_grant%0d: if_req_ready=%b if_resp_valid=%b, required 1 %b",
                     i, if_req_ready, if_resp_valid, i > 0);
         end
         if (i > 0) begin
            total++;
            if (cyc - last_grant !== 3) begin
               bad++;
               $display("FAIL b2b_period%0d: cycles=%0d, required 3", i, cyc - last_grant);
            end
         end
         last_grant = cyc;
         sb.push_back('{1'b0, 32'h5500_0000 + 32'(i)});
         tick();
         total++;
         if (mem_addr !== 32'h8000_0100 + 32'(i * 4) || if_resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_req%0d: addr=%h if_resp_valid=%b, required %h 0",
                     i, mem_addr, if_resp_valid, 32'h8000_0100 + 32'(i * 4));
         end
         mem_cycle(0, 32'h5500_0000 + 32'(i));
      end
      if_req_valid = 1'b0;
      #1;
      total++;
      if (if_resp_valid !== 1'b1) begin
         bad++;
         $display("FAIL b2b_last: if_resp_valid=%b, required 1", if_resp_valid);
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n          = 1'b0;
      if_req_valid   = 1'b0;
      if_req_addr    = '0;
      ls_req_valid   = 1'b0;
      ls_req_addr    = '0;
      ls_req_wen     = 1'b0;
      ls_req_wdata   = '0;
      ls_req_wmask   = 4'd0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      repeat (2) @(posedge clk);
      test_reset();
      test_ifu_alone();
      test_lsu_store_stall();
      test_simultaneous();
      test_starvation();
      test_spurious_and_reset();
      test_back_to_back();
      tick();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: outstanding=%0d, required 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
